dtc_tree_walker: RTL and testbench

- Sequential, table-driven decision-tree classifier for the dt classifier family.
- The node table is written through a config port. The walker reads it one node per cycle, starting at the root, until it reaches a leaf, then returns a 2-bit class.
- Sits between a feature-vector source and a class consumer. Both sides use valid/ready handshakes.

---
 rtl/dtc_tree_walker_if.sv | 42 ++++
 rtl/dtc_tree_walker.sv | 148 ++++++++++++++
 tb/tb_dtc_tree_walker.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtc_tree_walker_if.sv
// Handshake and config bundle for the decision-tree walker.
// The walker uses the slave modport. Its feature source, class consumer and table loader use master.
interface dtc_tree_walker_if #(
   parameter int unsigned N_FEAT  = 8,
   parameter int unsigned FIDX_W  = 3,
   parameter int unsigned CLASS_W = 2,
   parameter int unsigned ADDR_W  = 5
);
   localparam int unsigned NODE_W = 1 + FIDX_W + CLASS_W + 2 * ADDR_W;

   logic                cfg_we;
   logic [ADDR_W-1:0]   cfg_addr;
   logic [NODE_W-1:0]   cfg_wdata;
   logic                cfg_ack;

   logic                in_valid;
   logic                in_ready;
   logic [N_FEAT-1:0]   in_feat;

   logic                out_valid;
   logic                out_ready;
   logic [CLASS_W-1:0]  out_class;
   logic                out_err;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata,
      input  cfg_ack,
      output in_valid, in_feat,
      input  in_ready,
      input  out_valid, out_class, out_err,
      output out_ready
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata,
      output cfg_ack,
      input  in_valid, in_feat,
      output in_ready,
      output out_valid, out_class, out_err,
      input  out_ready
   );
endinterface

// File: rtl/dtc_tree_walker.sv
// Sequential decision-tree classifier. It walks a writable node table one node per cycle, from the root to a leaf.
// Node word, MSB first: is_leaf, feat_idx, class, nxt1, nxt0.
module dtc_tree_walker #(
   parameter int unsigned N_FEAT    = 8,
   parameter int unsigned FIDX_W    = 3,
   parameter int unsigned CLASS_W   = 2,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned MAX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   dtc_tree_walker_if.slave  bus
);
   localparam int unsigned NODE_W  = 1 + FIDX_W + CLASS_W + 2 * ADDR_W;
   localparam int unsigned N_NODES = 2 ** ADDR_W;
   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
   localparam int unsigned FEXT_W  = 2 ** FIDX_W;

   typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

   state_e               state_q, state_d;
   logic [NODE_W-1:0]    table_q [N_NODES];
   logic [N_FEAT-1:0]    feat_q, feat_d;
   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic [CLASS_W-1:0]   class_q, class_d;
   logic                 err_q, err_d;
   logic                 ack_q;
   logic                 wr_accept;

   logic [NODE_W-1:0]    node;
   logic                 node_leaf;
   logic [FIDX_W-1:0]    node_fidx;
   logic [CLASS_W-1:0]   node_class;
   logic [ADDR_W-1:0]    node_nxt1, node_nxt0;
   logic [FEXT_W-1:0]    feat_ext;
   logic                 feat_bit;

   // The table is writable only while no walk is in flight.
   assign wr_accept = bus.cfg_we && (state_q == StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         table_q <= '{default: '0};
      end else if (wr_accept) begin
         table_q[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= wr_accept;
      end
   end

   assign node = table_q[ptr_q];
   assign {node_leaf, node_fidx, node_class, node_nxt1, node_nxt0} = node;

   // Feature indices past the vector width read as feature bit 0.
   for (genvar i = 0; i < FEXT_W; i++) begin : g_feat_ext
      if (i < N_FEAT) begin : g_in
         assign feat_ext[i] = feat_q[i];
      end else begin : g_out
         assign feat_ext[i] = feat_q[0];
      end
   end
   assign feat_bit = feat_ext[node_fidx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      feat_d  = feat_q;
      ptr_d   = ptr_q;
      depth_d = depth_q;
      class_d = class_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               feat_d  = bus.in_feat;
               ptr_d   = '0;
               depth_d = '0;
               state_d = StWalk;
            end
         end
         StWalk: begin
            if (node_leaf) begin
               class_d = node_class;
               err_d   = 1'b0;
               state_d = StDone;
            end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
               // Depth limit also breaks any loop in the table.
               class_d = '0;
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               ptr_d   = feat_bit ? node_nxt1 : node_nxt0;
               depth_d = depth_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         StIdle:  bus.in_ready  = 1'b1;
         StDone:  bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         feat_q  <= '0;
         ptr_q   <= '0;
         depth_q <= '0;
         class_q <= '0;
         err_q   <= 1'b0;
      end else begin
         feat_q  <= feat_d;
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         class_q <= class_d;
         err_q   <= err_d;
      end
   end

   assign bus.out_class = class_q;
   assign bus.out_err   = err_q;
   assign bus.cfg_ack   = ack_q;
endmodule

// File: tb/tb_dtc_tree_walker.sv
// Self-checking bench for dtc_tree_walker. It holds a behavioural table/timeline model and runs directed walks.
module tb_dtc_tree_walker;
   localparam int unsigned N_FEAT    = 8;
   localparam int unsigned FIDX_W    = 3;
   localparam int unsigned CLASS_W   = 2;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned MAX_DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dtc_tree_walker_if #(
      .N_FEAT(N_FEAT), .FIDX_W(FIDX_W), .CLASS_W(CLASS_W), .ADDR_W(ADDR_W)
   ) bus ();

   dtc_tree_walker #(
      .N_FEAT(N_FEAT), .FIDX_W(FIDX_W), .CLASS_W(CLASS_W), .ADDR_W(ADDR_W),
      .MAX_DEPTH(MAX_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_tbl [32];
   int m_phase;   // 0 accepting, 1 walking, 2 presenting result
   int m_cnt;
   int m_class;
   int m_err;
   int m_ack;

   // Result code: depth | class<<8 | err<<16. A write on the accept cycle is visible to the walk.
   function automatic int classify(input logic [7:0] f, input bit we, input logic [4:0] wa,
                                   input logic [15:0] wd);
      int p;
      int fi;
      bit b;
      logic [15:0] n;
      p = 0;
      for (int k = 0; k <= int'(MAX_DEPTH); k++) begin
         n = (we && p == int'(wa)) ? wd : m_tbl[p];
         if (n[15]) return k | (int'(n[11:10]) << 8);
         if (k == int'(MAX_DEPTH)) return k | (1 << 16);
         fi = int'(n[14:12]);
         b  = (fi < int'(N_FEAT)) ? f[fi] : f[0];
         p  = b ? int'(n[9:5]) : int'(n[4:0]);
      end
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_tbl[i] <= '0;
         m_phase <= 0;
         m_cnt   <= 0;
         m_class <= 0;
         m_err   <= 0;
         m_ack   <= 0;
      end else begin
         m_ack <= 0;
         case (m_phase)
            0: begin
               if (bus.cfg_we) begin
                  m_tbl[bus.cfg_addr] <= bus.cfg_wdata;
                  m_ack <= 1;
               end
               if (bus.in_valid) begin
                  // out_valid rises d+1 cycles after the accept edge
                  m_cnt   <= (classify(bus.in_feat, bus.cfg_we, bus.cfg_addr, bus.cfg_wdata)
                              & 255) + 1;
                  m_class <= (classify(bus.in_feat, bus.cfg_we, bus.cfg_addr, bus.cfg_wdata)
                              >> 8) & 3;
                  m_err   <= (classify(bus.in_feat, bus.cfg_we, bus.cfg_addr, bus.cfg_wdata)
                              >> 16) & 1;
                  m_phase <= 1;
               end
            end
            1: begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) m_phase <= 2;
            end
            default: begin
               if (bus.out_ready) m_phase <= 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp_in_ready", int'(bus.in_ready), int'(m_phase == 0));
         chk("cmp_out_valid", int'(bus.out_valid), int'(m_phase == 2));
         chk("cmp_cfg_ack", int'(bus.cfg_ack), m_ack);
         if (m_phase == 2) begin
            chk("cmp_out_class", int'(bus.out_class), m_class);
            chk("cmp_out_err", int'(bus.out_err), m_err);
         end
      end
   end

   // ---------------- back-to-back logging ----------------
   int cyc = 0;
   bit log_en = 1'b0;
   int acc_q[$];
   int res_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (log_en && !rst) begin
         if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
         if (bus.out_valid && bus.out_ready) res_q.push_back(int'(bus.out_class));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we = 1'b0;
      chk("cfg_ack_high", int'(bus.cfg_ack), 1);
      tick();
      chk("cfg_ack_pulse", int'(bus.cfg_ack), 0);
   endtask

   // One full transaction. inj tries a node1 write during the walk, which must be dropped.
   task automatic walk(input logic [7:0] f, input int hold, input bit inj, input int exp_lat,
                       input int exp_cls, input int exp_err);
      int n;
      int lat;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("accept_ready", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_feat  = f;
      tick();
      bus.in_valid = 1'b0;
      if (inj) begin
         bus.cfg_we    = 1'b1;
         bus.cfg_addr  = 5'd1;
         bus.cfg_wdata = 16'h8C00;
      end
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
         bus.cfg_we = 1'b0;
         if (inj && lat == 1) chk("dropped_write_ack", int'(bus.cfg_ack), 0);
      end
      chk("latency", lat, exp_lat);
      chk("out_class", int'(bus.out_class), exp_cls);
      chk("out_err", int'(bus.out_err), exp_err);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", int'(bus.out_valid), 1);
         chk("hold_class", int'(bus.out_class), exp_cls);
         chk("hold_in_ready", int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("in_ready_after_hs", int'(bus.in_ready), 1);
   endtask

   logic [7:0] seq [4];
   int exp_b2b_cls [4];
   int exp_b2b_d [4];

   initial begin
      int n;
      int seen;
      seq         = '{8'h40, 8'h00, 8'h40, 8'h00};
      exp_b2b_cls = '{2, 3, 2, 3};
      exp_b2b_d   = '{1, 3, 1, 3};
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      bus.in_valid  = 1'b0;
      bus.in_feat   = '0;
      bus.out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_class", int'(bus.out_class), 0);
      chk("rst_out_err", int'(bus.out_err), 0);
      chk("rst_cfg_ack", int'(bus.cfg_ack), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // The all-zero table loops at node 0 until the depth limit.
      walk(8'hFF, 0, 1'b0, 9, 0, 1);

      // Two-level tree on feature 6.
      cfg_write(5'd0, 16'h6041);
      cfg_write(5'd1, 16'h8400);
      cfg_write(5'd2, 16'h8800);
      walk(8'h40, 0, 1'b0, 2, 2, 0);
      walk(8'h00, 0, 1'b0, 2, 1, 0);

      // Root leaf with back-pressure.
      cfg_write(5'd0, 16'h8C00);
      walk(8'h00, 5, 1'b0, 1, 3, 0);

      // A write during the walk is dropped.
      cfg_write(5'd0, 16'h6041);
      walk(8'h00, 0, 1'b1, 2, 1, 0);
      walk(8'h00, 0, 1'b0, 2, 1, 0);

      // Three-deep path 0 -> 1 -> 3 -> 4.
      cfg_write(5'd1, 16'h0063);
      cfg_write(5'd3, 16'h1084);
      cfg_write(5'd4, 16'h8C00);
      walk(8'h00, 0, 1'b0, 4, 3, 0);

      // Reset in the middle of the same walk.
      bus.in_valid = 1'b1;
      bus.in_feat  = 8'h00;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_in_ready", int'(bus.in_ready), 1);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_out_class", int'(bus.out_class), 0);
      chk("midrst_out_err", int'(bus.out_err), 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      chk("midrst_no_valid", seen, 0);
      walk(8'h00, 0, 1'b0, 9, 0, 1);

      // Back-to-back traffic on a mixed-depth tree.
      cfg_write(5'd0, 16'h6041);
      cfg_write(5'd1, 16'h0063);
      cfg_write(5'd2, 16'h8800);
      cfg_write(5'd3, 16'h1084);
      cfg_write(5'd4, 16'h8C00);
      log_en        = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_feat   = seq[0];
      bus.in_valid  = 1'b1;
      n = 0;
      while (res_q.size() < 4 && n < 80) begin
         tick();
         n++;
         if (acc_q.size() < 4) bus.in_feat = seq[acc_q.size()];
         else bus.in_valid = 1'b0;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      log_en        = 1'b0;
      chk("b2b_results", res_q.size(), 4);
      chk("b2b_accepts", acc_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_class", (i < res_q.size()) ? res_q[i] : -1, exp_b2b_cls[i]);
      end
      // Accept spacing: d+1 walk cycles, one result cycle, one idle cycle.
      for (int i = 0; i < 3; i++) begin
         chk("b2b_spacing", (i + 1 < acc_q.size()) ? acc_q[i+1] - acc_q[i] : -1,
             exp_b2b_d[i] + 3);
      end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
